ifu_bus_ctrl: RTL and testbench

Instruction-fetch bus controller between `pc_reg` and the `fetch` stage. It takes the current PC, runs a read transaction on the instruction-memory bus (AR/R valid–ready handshake, 64-bit beat) and presents the selected 32-bit instruction word to `fetch` with a valid flag. While that flag is low, `fetch` raises its stall request. It tracks PC changes by itself, so flushes and redirects need no extra control input.

---
 rtl/ifu_bus_ctrl_pkg.sv | 12 +
 rtl/ifu_bus_ctrl.sv | 67 ++++++
 tb/tb_ifu_bus_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ifu_bus_ctrl_pkg.sv
// ifu_bus_ctrl_pkg: bus widths, NOP encoding and FSM states for the fetch bus controller
package ifu_bus_ctrl_pkg;
  localparam int XLEN = 64;
  localparam int NPC_ADDR = 32;
  localparam logic [XLEN-1:0] INST_NOP = 64'h0000_0000_0000_0013;
  typedef enum logic [1:0] {
    IFU_ST_IDLE = 2'd0,
    IFU_ST_AR   = 2'd1,
    IFU_ST_R    = 2'd2,
    IFU_ST_HOLD = 2'd3
  } ifu_state_e;
endpackage

// File: rtl/ifu_bus_ctrl.sv
// ifu_bus_ctrl: single-outstanding instruction fetch over an AR/R bus, serving one held 64-bit beat.
// IFU_LINE_BUF_EN: also serve the other 32-bit half of the held beat without a new read.
module ifu_bus_ctrl
  import ifu_bus_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_now_i,
  output logic [NPC_ADDR-1:0] if_araddr_o,
  output logic                if_arvalid_o,
  input  logic                if_arready_i,
  input  logic [XLEN-1:0]     if_rdata_i,
  input  logic [1:0]          if_rresp_i,
  input  logic                if_rvalid_i,
  output logic                if_rready_o,
  output logic                if_rdata_valid_o,
  output logic [XLEN-1:0]     if_rdata_o,
  output logic                if_access_fault_o
);
  ifu_state_e      state_q;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] buf_data_q;
  logic            buf_fault_q;
  logic            exact;
  logic            hit;
  logic [31:0]     word;
  assign exact = pc_now_i == req_addr_q;
`ifdef IFU_LINE_BUF_EN
  assign hit = pc_now_i[XLEN-1:3] == req_addr_q[XLEN-1:3];
`else
  assign hit = exact;
`endif
  // a beat is only kept if the PC still matches when it arrives, so no stale word is ever served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IFU_ST_IDLE;
      req_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_fault_q <= 1'b0;
    end else begin
      case (state_q)
        IFU_ST_IDLE: begin
          req_addr_q <= pc_now_i;
          state_q    <= IFU_ST_AR;
        end
        IFU_ST_AR: if (if_arready_i) state_q <= IFU_ST_R;
        IFU_ST_R: if (if_rvalid_i) begin
          buf_data_q  <= if_rdata_i;
          buf_fault_q <= |if_rresp_i;
          if (!exact) req_addr_q <= pc_now_i;
          state_q <= exact ? IFU_ST_HOLD : IFU_ST_AR;
        end
        IFU_ST_HOLD: if (!hit) begin
          req_addr_q <= pc_now_i;
          state_q    <= IFU_ST_AR;
        end
      endcase
    end
  end
  assign if_araddr_o       = {req_addr_q[NPC_ADDR-1:3], 3'b000};
  assign if_arvalid_o      = state_q == IFU_ST_AR;
  assign if_rready_o       = state_q == IFU_ST_R;
  assign if_rdata_valid_o  = (state_q == IFU_ST_HOLD) && hit;
  assign if_access_fault_o = if_rdata_valid_o && buf_fault_q;
  assign word              = pc_now_i[2] ? buf_data_q[63:32] : buf_data_q[31:0];
  assign if_rdata_o        = (if_rdata_valid_o && !buf_fault_q) ? {32'b0, word} : INST_NOP;
endmodule

// File: tb/tb_ifu_bus_ctrl.sv
// tb_ifu_bus_ctrl: directed checks of fetch latency, bus waits, redirect, fault, line buffer and reset.
module tb_ifu_bus_ctrl;
  logic        clk;
  logic        rst;
  logic [63:0] pc_now;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata_bus;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rdata_valid;
  logic [63:0] rdata;
  logic        fault;
  int checks = 0;
  int errors = 0;
  logic seen_valid;

  localparam logic [63:0] NOP = 64'h13;

  ifu_bus_ctrl dut (
    .clk(clk), .rst(rst), .pc_now_i(pc_now),
    .if_araddr_o(araddr), .if_arvalid_o(arvalid), .if_arready_i(arready),
    .if_rdata_i(rdata_bus), .if_rresp_i(rresp), .if_rvalid_i(rvalid), .if_rready_o(rready),
    .if_rdata_valid_o(rdata_valid), .if_rdata_o(rdata), .if_access_fault_o(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    chk({tag, "_rready"}, 64'(rready), 64'd0);
    chk({tag, "_valid"}, 64'(rdata_valid), 64'd0);
    chk({tag, "_fault"}, 64'(fault), 64'd0);
    chk({tag, "_araddr"}, 64'(araddr), 64'd0);
    chk({tag, "_rdata"}, rdata, NOP);
  endtask

  initial begin
    rst = 1'b1;
    pc_now = 64'h8000_0000;
    arready = 1'b1;
    rvalid = 1'b1;
    rresp = 2'b00;
    rdata_bus = 64'h0000_0013_0000_0297;
    tick;
    tick;
    chk_reset_outputs("reset");
    // first fetch: cycle 1 IDLE, 2 AR, 3 R, 4 valid
    rst = 1'b0;
    chk("c1_arvalid", 64'(arvalid), 64'd0);
    tick;
    chk("c2_arvalid", 64'(arvalid), 64'd1);
    chk("c2_araddr", 64'(araddr), 64'h8000_0000);
    tick;
    chk("c3_rready", 64'(rready), 64'd1);
    chk("c3_valid", 64'(rdata_valid), 64'd0);
    tick;
    chk("c4_valid", 64'(rdata_valid), 64'd1);
    chk("c4_rdata", rdata, 64'h0000_0297);
    chk("c4_fault", 64'(fault), 64'd0);
    tick;
    chk("hold_valid", 64'(rdata_valid), 64'd1);
    chk("hold_arvalid", 64'(arvalid), 64'd0);

    // bus waits: arready 2 cycles late, rvalid 3 cycles late -> valid at t+8
    pc_now = 64'h8000_0200;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata_bus = 64'h1111_2222_3333_4444;
    #1;
    chk("miss_drop_valid", 64'(rdata_valid), 64'd0);
    seen_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick;
      arready = (c == 3);
      rvalid = (c == 7);
      if (rdata_valid) seen_valid = 1'b1;
      if (c <= 3) begin
        chk("wait_arvalid", 64'(arvalid), 64'd1);
        chk("wait_araddr", 64'(araddr), 64'h8000_0200);
      end
    end
    chk("wait_no_early_valid", 64'(seen_valid), 64'd0);
    tick;
    chk("wait_valid_t8", 64'(rdata_valid), 64'd1);
    chk("wait_rdata", rdata, 64'h3333_4444);

    // redirect while in R
    arready = 1'b1;
    rvalid = 1'b0;
    pc_now = 64'h8000_0000;
    tick;
    chk("redir_araddr1", 64'(araddr), 64'h8000_0000);
    tick;
    chk("redir_rready", 64'(rready), 64'd1);
    pc_now = 64'h8000_0100;
    rvalid = 1'b1;
    rdata_bus = 64'hdead_beef_dead_beef;
    #1;
    chk("redir_valid_r", 64'(rdata_valid), 64'd0);
    tick;
    chk("redir_arvalid2", 64'(arvalid), 64'd1);
    chk("redir_araddr2", 64'(araddr), 64'h8000_0100);
    chk("redir_valid_ar", 64'(rdata_valid), 64'd0);
    rdata_bus = 64'h0000_00aa_0000_00bb;
    tick;
    chk("redir_valid_r2", 64'(rdata_valid), 64'd0);
    tick;
    chk("redir_valid", 64'(rdata_valid), 64'd1);
    chk("redir_rdata", rdata, 64'h0000_00bb);

    // access fault
    pc_now = 64'h8000_0300;
    rresp = 2'b10;
    tick;
    tick;
    tick;
    chk("fault_valid", 64'(rdata_valid), 64'd1);
    chk("fault_flag", 64'(fault), 64'd1);
    chk("fault_rdata", rdata, NOP);
    rresp = 2'b00;

    // line buffer
    pc_now = 64'h8000_0000;
    rdata_bus = 64'h0000_0013_0000_0297;
    tick;
    tick;
    tick;
    chk("lb_valid0", 64'(rdata_valid), 64'd1);
    chk("lb_fault0", 64'(fault), 64'd0);
    chk("lb_rdata0", rdata, 64'h0000_0297);
    pc_now = 64'h8000_0004;
    #1;
`ifdef IFU_LINE_BUF_EN
    chk("lb_same_cycle_valid", 64'(rdata_valid), 64'd1);
    chk("lb_same_cycle_rdata", rdata, 64'h0000_0013);
    tick;
    chk("lb_no_ar", 64'(arvalid), 64'd0);
    chk("lb_still_valid", 64'(rdata_valid), 64'd1);
`else
    chk("nolb_valid_drop", 64'(rdata_valid), 64'd0);
    tick;
    chk("nolb_arvalid", 64'(arvalid), 64'd1);
    chk("nolb_araddr", 64'(araddr), 64'h8000_0000);
    tick;
    tick;
    chk("nolb_valid", 64'(rdata_valid), 64'd1);
    chk("nolb_rdata", rdata, 64'h0000_0013);
`endif

    // reset mid-operation while in R
    pc_now = 64'h8000_0400;
    rvalid = 1'b0;
    rdata_bus = 64'h0000_0555_0000_0666;
    tick;
    tick;
    chk("mid_rready", 64'(rready), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    rvalid = 1'b1;
    tick;
    chk_reset_outputs("midrst_stray");
    rst = 1'b0;
    tick;
    chk("after_rst_araddr", 64'(araddr), 64'h8000_0400);
    tick;
    tick;
    chk("after_rst_valid", 64'(rdata_valid), 64'd1);
    chk("after_rst_rdata", rdata, 64'h0000_0666);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
